// File: rtl/ln_scale_decomp_pkg.sv
// rtl/ln_scale_decomp_pkg.sv - shared PE constants for the ln scale decomposition
// Threshold table round(e^k*256) for k = 2 down to -6, state enum and k range.
package ln_scale_decomp_pkg;

   localparam int LN_DATA_W   = 12;
   localparam int LN_FRAC_W   = 8;
   localparam int LN_EXP_W    = 4;
   localparam int LN_K_MAX    = 2;
   localparam int LN_K_MIN    = -6;
   localparam int LN_N_THRESH = LN_K_MAX - LN_K_MIN + 1;

   typedef logic [LN_DATA_W-1:0] ln_scale_t;

   typedef enum logic [1:0] {
      IDLE,
      SEARCH,
      DONE
   } ln_state_t;

   // Entry i holds THRESH[LN_K_MAX - i].
   localparam ln_scale_t LN_THRESH [LN_N_THRESH] = '{
      12'd1892, 12'd696, 12'd256, 12'd94, 12'd35, 12'd13, 12'd5, 12'd2, 12'd1
   };

endpackage

// File: rtl/ln_scale_decomp_if.sv
// rtl/ln_scale_decomp_if.sv - request/result handshake bundle for ln_scale_decomp
// slave: the decomposition block; master: the producer/consumer driving it.
interface ln_scale_decomp_if #(
   parameter int DATA_W = 12,
   parameter int EXP_W  = 4
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_x;
   logic              out_valid;
   logic              out_ready;
   logic [EXP_W-1:0]  out_exp;
   logic [DATA_W-1:0] out_resid;
   logic              out_zero;

   modport slave (
      input  in_valid, in_x, out_ready,
      output in_ready, out_valid, out_exp, out_resid, out_zero
   );

   modport master (
      output in_valid, in_x, out_ready,
      input  in_ready, out_valid, out_exp, out_resid, out_zero
   );

endinterface

// File: rtl/ln_scale_decomp_thresh_rom.sv
// rtl/ln_scale_decomp_thresh_rom.sv - combinational k -> round(e^k*256) lookup
// Any k outside [LN_K_MIN, LN_K_MAX] returns 0.
module ln_thresh_rom
   import ln_scale_decomp_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int EXP_W  = 4
) (
   input  logic signed [EXP_W-1:0]  k,
   output logic        [DATA_W-1:0] thresh
);

   always_comb begin
      thresh = '0;
      for (int i = 0; i < LN_N_THRESH; i++) begin
         if (k == EXP_W'(LN_K_MAX - i))
            thresh = DATA_W'(LN_THRESH[i]);
      end
   end

endmodule

// File: rtl/ln_scale_decomp.sv
// rtl/ln_scale_decomp.sv - iterative search for k with THRESH[k] <= x < THRESH[k+1]
// Optional residual output enabled by LN_SCALE_RESID_EN; otherwise out_resid is tied to 0.
module ln_scale_decomp
   import ln_scale_decomp_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int FRAC_W = 8,
   parameter int EXP_W  = 4
) (
   input  logic                clock,
   input  logic                rst_n,
   ln_scale_decomp_if.slave    bus
);

   if (DATA_W != LN_DATA_W || FRAC_W != LN_FRAC_W || EXP_W != LN_EXP_W) begin : g_bad_param
      $error("ln_scale_decomp: threshold table only defined for DATA_W=12 FRAC_W=8 EXP_W=4");
   end

   localparam logic signed [EXP_W-1:0] K_MAX     = EXP_W'(LN_K_MAX);
   localparam logic signed [EXP_W-1:0] K_MIN     = EXP_W'(LN_K_MIN);
   localparam logic        [EXP_W-1:0] EXP_ZERO  = {1'b1, {(EXP_W-1){1'b0}}};

   ln_state_t                state_q, state_d;
   logic signed [EXP_W-1:0]  k_q, k_d;
   logic        [DATA_W-1:0] x_q, x_d;
   logic        [EXP_W-1:0]  exp_q, exp_d;
   logic                     zero_q, zero_d;
   logic        [DATA_W-1:0] thresh;
   logic                     accept;
   logic                     accept_zero;
   logic                     term;

   ln_thresh_rom #(
      .DATA_W (DATA_W),
      .EXP_W  (EXP_W)
   ) u_rom (
      .k      (k_q),
      .thresh (thresh)
   );

   assign accept      = (state_q == IDLE) && bus.in_valid;
   assign accept_zero = accept && (bus.in_x == '0);
   // THRESH[K_MIN] is 1, so the floor stop only matters as a safety net.
   assign term        = (state_q == SEARCH) && ((x_q >= thresh) || (k_q == K_MIN));

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         k_q     <= '0;
         x_q     <= '0;
         exp_q   <= '0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         k_q     <= k_d;
         x_q     <= x_d;
         exp_q   <= exp_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      x_d     = x_q;
      exp_d   = exp_q;
      zero_d  = zero_q;
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               x_d = bus.in_x;
               k_d = K_MAX;
               if (bus.in_x == '0) begin
                  exp_d   = EXP_ZERO;
                  zero_d  = 1'b1;
                  state_d = DONE;
               end else begin
                  state_d = SEARCH;
               end
            end
         end
         SEARCH: begin
            if (term) begin
               exp_d   = k_q;
               zero_d  = 1'b0;
               state_d = DONE;
            end else begin
               k_d = k_q - EXP_W'(1);
            end
         end
         DONE: begin
            if (bus.out_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef LN_SCALE_RESID_EN
   logic [DATA_W-1:0] resid_q, resid_d;

   always_comb begin
      resid_d = resid_q;
      if (accept_zero)
         resid_d = '0;
      else if (term)
         resid_d = x_q - thresh;
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n)
         resid_q <= '0;
      else
         resid_q <= resid_d;
   end

   assign bus.out_resid = resid_q;
`else
   assign bus.out_resid = '0;
`endif

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.out_exp   = exp_q;
   assign bus.out_zero  = zero_q;

endmodule

// File: tb/tb_ln_scale_decomp.sv
// tb/tb_ln_scale_decomp.sv - randomized self-checking bench for ln_scale_decomp
// Inputs change 2 time units after posedge; a negedge monitor checks against a search model.
module tb_ln_scale_decomp;

   localparam int TH [9] = '{1892, 696, 256, 94, 35, 13, 5, 2, 1};

   logic clock;
   logic rst_n;
   int   n_vec;
   int   n_err;
   int   cyc;

   ln_scale_decomp_if #(.DATA_W(12), .EXP_W(4)) bus ();

   ln_scale_decomp dut (
      .clock (clock),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic int m_k(input int x);
      if (x == 0) return -8;
      for (int i = 0; i < 9; i++)
         if (x >= TH[i]) return 2 - i;
      return -6;
   endfunction

   function automatic int m_resid(input int x);
`ifdef LN_SCALE_RESID_EN
      if (x == 0) return 0;
      return x - TH[2 - m_k(x)];
`else
      return 0 * x;
`endif
   endfunction

   function automatic int m_lat(input int x);
      if (x == 0) return 1;
      return (2 - m_k(x)) + 2;
   endfunction

   task automatic check(input string nm, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Monitor: at each negedge the values seen are exactly those the next posedge will sample.
   bit pend, seen;
   int p_x, p_acc;
   int last_exp, last_resid, last_zero;

   always @(negedge clock) begin
      cyc++;
      if (!rst_n) begin
         pend = 0;
         last_exp = 0; last_resid = 0; last_zero = 0;
         check("rst_out_valid", int'(bus.out_valid), 0);
         check("rst_in_ready", int'(bus.in_ready), 1);
         check("rst_out_exp", int'(bus.out_exp), 0);
         check("rst_out_resid", int'(bus.out_resid), 0);
         check("rst_out_zero", int'(bus.out_zero), 0);
      end else begin
         if (bus.out_valid) begin
            if (!pend) begin
               check("spurious_out_valid", 1, 0);
            end else begin
               if (!seen) begin
                  seen = 1;
                  check("latency", cyc - p_acc, m_lat(p_x));
               end
               check("out_exp", int'($signed(bus.out_exp)), m_k(p_x));
               check("out_resid", int'(bus.out_resid), m_resid(p_x));
               check("out_zero", int'(bus.out_zero), int'(p_x == 0));
               check("in_ready_in_done", int'(bus.in_ready), 0);
               last_exp   = m_k(p_x) & 15;
               last_resid = m_resid(p_x);
               last_zero  = int'(p_x == 0);
               if (bus.out_ready) pend = 0;
            end
         end else begin
            check("hold_out_exp", int'(bus.out_exp), last_exp);
            check("hold_out_resid", int'(bus.out_resid), last_resid);
            check("hold_out_zero", int'(bus.out_zero), last_zero);
         end
         if (bus.in_valid && bus.in_ready) begin
            if (pend) check("accept_while_busy", 1, 0);
            pend  = 1;
            seen  = 0;
            p_x   = int'(bus.in_x);
            p_acc = cyc;
         end
      end
   end

   task automatic step();
      @(posedge clock);
      #2;
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!bus.in_ready && t < 50) begin step(); t++; end
      if (!bus.in_ready) check("timeout_in_ready", 0, 1);
   endtask

   task automatic op(input int x, input int hold, input bit junk);
      int t = 0;
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_x     = 12'(x);
      step();
      bus.in_valid = 1'b0;
      while (!bus.out_valid && t < 20) begin step(); t++; end
      if (!bus.out_valid) begin
         check("timeout_out_valid", 0, 1);
         return;
      end
      for (int i = 0; i < hold; i++) begin
         bus.out_ready = 1'b0;
         bus.in_valid  = junk;
         bus.in_x      = 12'($urandom_range(0, 4095));
         step();
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      step();
      bus.out_ready = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_err = 0; cyc = 0;
      rst_n = 1'b0;
      bus.in_valid = 1'b0; bus.in_x = '0; bus.out_ready = 1'b0;

      check("model_k_256", m_k(256), 0);
      check("model_k_1000", m_k(1000), 1);
      check("model_k_4095", m_k(4095), 2);
      check("model_k_1", m_k(1), -6);
      check("model_k_35", m_k(35), -2);
      check("model_lat_256", m_lat(256), 4);
      check("model_lat_1000", m_lat(1000), 3);
      check("model_lat_4095", m_lat(4095), 2);
      check("model_lat_1", m_lat(1), 10);
      check("model_lat_0", m_lat(0), 1);
`ifdef LN_SCALE_RESID_EN
      check("model_resid_1000", m_resid(1000), 304);
      check("model_resid_4095", m_resid(4095), 2203);
`endif

      repeat (3) step();
      rst_n = 1'b1;
      step();

      op(256, 0, 0);
      op(1000, 0, 0);
      op(4095, 0, 0);
      op(1, 0, 0);
      op(0, 0, 0);
      op(500, 5, 1);

      foreach (TH[i]) begin
         op(TH[i] - 1, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
         op(TH[i], 0, 0);
         op(TH[i] + 1, 1, 1);
      end

      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_x     = 12'd1;
      step();
      bus.in_valid = 1'b0;
      repeat (3) step();
      rst_n = 1'b0;
      repeat (2) step();
      rst_n = 1'b1;
      step();
      op(35, 0, 0);

      for (int n = 0; n < 150; n++) begin
         int x;
         case ($urandom_range(0, 3))
            0:       x = $urandom_range(0, 4095);
            1:       x = $urandom_range(0, 40);
            2:       x = TH[$urandom_range(0, 8)] + int'($urandom_range(0, 2)) - 1;
            default: x = $urandom_range(0, 300);
         endcase
         op(x, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      repeat (3) step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
